// File: rtl/abro_pkg.sv
// Shared types and defaults for the ABRO input conditioning path.
// Debounce state encoding plus the default channel parameters.
package abro_pkg;

  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    PEND_HI   = 2'd1,
    STABLE_HI = 2'd2,
    PEND_LO   = 2'd3
  } debounce_state_t;

  localparam int unsigned GLITCH_W_DEFAULT = 8;
  localparam int unsigned DEBOUNCE_DEFAULT = 4;

  // Width of a counter that must be able to hold the value n.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One button channel: two-flop synchroniser, debounce FSM, registered
// edge pulses and a saturating count of rejected transitions.
module debounce_channel
  import abro_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int unsigned GLITCH_W        = GLITCH_W_DEFAULT
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                i_raw,
  input  logic                i_glitch_clr,
  output logic                o_clean,
  output logic                o_rise,
  output logic                o_fall,
  output logic [GLITCH_W-1:0] o_glitch_cnt
);

  localparam int unsigned          CNT_W      = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0]     CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0]     CNT_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [GLITCH_W-1:0]  GLITCH_MAX = '1;

  logic                r_s1;
  logic                r_s2;
  debounce_state_t     r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_clean;
  logic                r_rise;
  logic                r_fall;
  logic [GLITCH_W-1:0] r_glitch;

  debounce_state_t     w_state_nxt;
  logic [CNT_W-1:0]    w_cnt_nxt;
  logic                w_clean_nxt;
  logic                w_rise_nxt;
  logic                w_fall_nxt;
  logic                w_abort;

  // NOTE: every flop uses non-blocking assignment so all registers see pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
    end else begin
      r_s1 <= i_raw;
      r_s2 <= r_s1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= STABLE_LO;
      r_cnt   <= '0;
      r_clean <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_clean <= w_clean_nxt;
      r_rise  <= w_rise_nxt;
      r_fall  <= w_fall_nxt;
    end
  end

  // NOTE: every combinational output is given a default first so no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_clean_nxt = r_clean;
    w_rise_nxt  = 1'b0;
    w_fall_nxt  = 1'b0;
    w_abort     = 1'b0;

    case (r_state)
      STABLE_LO: begin
        if (r_s2) begin
          w_state_nxt = PEND_HI;
          w_cnt_nxt   = CNT_ONE;
        end
      end
      PEND_HI: begin
        if (!r_s2) begin
          w_state_nxt = STABLE_LO;
          w_cnt_nxt   = '0;
          w_abort     = 1'b1;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = STABLE_HI;
          w_cnt_nxt   = '0;
          w_clean_nxt = 1'b1;
          w_rise_nxt  = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end
      STABLE_HI: begin
        if (!r_s2) begin
          w_state_nxt = PEND_LO;
          w_cnt_nxt   = CNT_ONE;
        end
      end
      PEND_LO: begin
        if (r_s2) begin
          w_state_nxt = STABLE_HI;
          w_cnt_nxt   = '0;
          w_abort     = 1'b1;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = STABLE_LO;
          w_cnt_nxt   = '0;
          w_clean_nxt = 1'b0;
          w_fall_nxt  = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end
      default: begin
        w_state_nxt = STABLE_LO;
        w_cnt_nxt   = '0;
        w_clean_nxt = 1'b0;
      end
    endcase
  end

  // Clear has priority over a same-cycle abort increment.
  always_ff @(posedge clock) begin
    if (reset || i_glitch_clr) begin
      r_glitch <= '0;
    end else if (w_abort && (r_glitch != GLITCH_MAX)) begin
      r_glitch <= r_glitch + GLITCH_W'(1);
    end
  end

  assign o_clean      = r_clean;
  assign o_rise       = r_rise;
  assign o_fall       = r_fall;
  assign o_glitch_cnt = r_glitch;

endmodule

// File: rtl/abro_input_conditioner.sv
// Conditions raw buttons A and B for the ABRO state machine.
// Two identical, independent debounce channels; DEBOUNCE_CYCLES legal range 2..255.
module abro_input_conditioner
  import abro_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int unsigned GLITCH_W        = GLITCH_W_DEFAULT
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                a_raw,
  input  logic                b_raw,
  input  logic                glitch_clr,
  output logic                a_clean,
  output logic                b_clean,
  output logic                a_rise,
  output logic                a_fall,
  output logic                b_rise,
  output logic                b_fall,
  output logic [GLITCH_W-1:0] a_glitch_cnt,
  output logic [GLITCH_W-1:0] b_glitch_cnt
);

  debounce_channel #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .GLITCH_W        (GLITCH_W)
  ) u_chan_a (
    .clock        (clock),
    .reset        (reset),
    .i_raw        (a_raw),
    .i_glitch_clr (glitch_clr),
    .o_clean      (a_clean),
    .o_rise       (a_rise),
    .o_fall       (a_fall),
    .o_glitch_cnt (a_glitch_cnt)
  );

  debounce_channel #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .GLITCH_W        (GLITCH_W)
  ) u_chan_b (
    .clock        (clock),
    .reset        (reset),
    .i_raw        (b_raw),
    .i_glitch_clr (glitch_clr),
    .o_clean      (b_clean),
    .o_rise       (b_rise),
    .o_fall       (b_fall),
    .o_glitch_cnt (b_glitch_cnt)
  );

endmodule

// File: tb/tb_abro_input_conditioner.sv
// Directed bench for abro_input_conditioner with default parameters.
// Inputs change 1 ns after a rising edge; outputs are sampled at the same point.
module tb_abro_input_conditioner;

  logic       clock = 1'b0;
  logic       reset;
  logic       a_raw;
  logic       b_raw;
  logic       glitch_clr;
  logic       a_clean;
  logic       b_clean;
  logic       a_rise;
  logic       a_fall;
  logic       b_rise;
  logic       b_fall;
  logic [7:0] a_glitch_cnt;
  logic [7:0] b_glitch_cnt;

  int n_checks = 0;
  int n_pass   = 0;
  int a_rise_n, a_fall_n, b_rise_n, b_fall_n, a_tog_n, b_tog_n;
  logic a_prev, b_prev;

  abro_input_conditioner dut (
    .clock        (clock),
    .reset        (reset),
    .a_raw        (a_raw),
    .b_raw        (b_raw),
    .glitch_clr   (glitch_clr),
    .a_clean      (a_clean),
    .b_clean      (b_clean),
    .a_rise       (a_rise),
    .a_fall       (a_fall),
    .b_rise       (b_rise),
    .b_fall       (b_fall),
    .a_glitch_cnt (a_glitch_cnt),
    .b_glitch_cnt (b_glitch_cnt)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual === expected) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, actual, expected);
  endtask

  // Advance one edge, then tally pulses and level toggles.
  task automatic step();
    @(posedge clock);
    #1;
    a_rise_n += int'(a_rise);
    a_fall_n += int'(a_fall);
    b_rise_n += int'(b_rise);
    b_fall_n += int'(b_fall);
    if (a_clean !== a_prev) a_tog_n++;
    if (b_clean !== b_prev) b_tog_n++;
    a_prev = a_clean;
    b_prev = b_clean;
  endtask

  task automatic clear_stats();
    a_rise_n = 0; a_fall_n = 0; b_rise_n = 0; b_fall_n = 0;
    a_tog_n  = 0; b_tog_n  = 0;
    a_prev   = a_clean;
    b_prev   = b_clean;
  endtask

  initial begin
    logic [21:0] all_out;
    logic [21:0] any_out;

    reset = 1'b1; a_raw = 1'b0; b_raw = 1'b0; glitch_clr = 1'b0;
    a_prev = 1'b0; b_prev = 1'b0;
    a_rise_n = 0; a_fall_n = 0; b_rise_n = 0; b_fall_n = 0; a_tog_n = 0; b_tog_n = 0;
    repeat (2) step();
    reset = 1'b0;

    // Reset state and 20 idle cycles.
    all_out = {a_clean, b_clean, a_rise, a_fall, b_rise, b_fall, a_glitch_cnt, b_glitch_cnt};
    check("reset_outputs", 32'(all_out), 32'd0);
    any_out = '0;
    for (int i = 0; i < 20; i++) begin
      step();
      any_out |= {a_clean, b_clean, a_rise, a_fall, b_rise, b_fall, a_glitch_cnt, b_glitch_cnt};
    end
    check("idle_20_cycles", 32'(any_out), 32'd0);

    // A step 0->1: clean and rise at edge 6.
    clear_stats();
    a_raw = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      step();
      check($sformatf("a_step_clean_e%0d", e), 32'(a_clean), (e >= 6) ? 32'd1 : 32'd0);
      check($sformatf("a_step_rise_e%0d", e), 32'(a_rise), (e == 6) ? 32'd1 : 32'd0);
    end
    check("a_step_rise_count", a_rise_n, 1);
    check("a_step_b_clean", 32'(b_clean), 32'd0);
    check("a_step_b_pulses", b_rise_n + b_fall_n, 0);
    a_raw = 1'b0;
    repeat (8) step();
    check("a_release_clean", 32'(a_clean), 32'd0);
    check("a_release_fall_count", a_fall_n, 1);

    // Bounce on B: high 3, low 2, then high.
    clear_stats();
    b_raw = 1'b1;
    repeat (3) step();
    b_raw = 1'b0;
    repeat (2) step();
    b_raw = 1'b1;
    step();
    check("b_bounce_glitch_e6", 32'(b_glitch_cnt), 32'd1);
    check("b_bounce_clean_e6", 32'(b_clean), 32'd0);
    for (int e = 7; e <= 12; e++) begin
      step();
      check($sformatf("b_bounce_clean_e%0d", e), 32'(b_clean), (e >= 11) ? 32'd1 : 32'd0);
      check($sformatf("b_bounce_rise_e%0d", e), 32'(b_rise), (e == 11) ? 32'd1 : 32'd0);
    end
    check("b_bounce_rise_count", b_rise_n, 1);
    check("b_bounce_glitch_final", 32'(b_glitch_cnt), 32'd1);
    b_raw = 1'b0;
    repeat (8) step();
    check("b_release_clean", 32'(b_clean), 32'd0);

    // 300 single-cycle A pulses saturate the A glitch counter.
    clear_stats();
    for (int p = 1; p <= 300; p++) begin
      a_raw = 1'b1;
      step();
      a_raw = 1'b0;
      repeat (3) step();
      if (p == 10) check("a_glitch_after_10", 32'(a_glitch_cnt), 32'd10);
    end
    check("a_glitch_saturated", 32'(a_glitch_cnt), 32'd255);
    check("a_sat_clean", 32'(a_clean), 32'd0);
    check("a_sat_pulses", a_rise_n + a_fall_n, 0);

    // Clear coincident with a further abort: clear wins.
    a_raw = 1'b1;
    step();
    a_raw = 1'b0;
    repeat (2) step();
    glitch_clr = 1'b1;
    step();
    glitch_clr = 1'b0;
    check("a_glitch_clr_wins", 32'(a_glitch_cnt), 32'd0);
    check("b_glitch_cleared", 32'(b_glitch_cnt), 32'd0);
    step();
    check("a_glitch_clr_hold", 32'(a_glitch_cnt), 32'd0);

    // Reset while A is pending with cnt = 2.
    clear_stats();
    a_raw = 1'b1;
    repeat (4) step();
    reset = 1'b1;
    step();
    check("rst_mid_pend_clean", 32'(a_clean), 32'd0);
    step();
    check("rst_mid_pend_no_rise", a_rise_n, 0);
    reset = 1'b0;
    for (int e = 1; e <= 6; e++) begin
      step();
      check($sformatf("rst_release_clean_e%0d", e), 32'(a_clean), (e == 6) ? 32'd1 : 32'd0);
    end
    check("rst_release_rise_count", a_rise_n, 1);
    a_raw = 1'b0;
    repeat (8) step();

    // Full ABRO-style sequence.
    clear_stats();
    a_raw = 1'b1; repeat (10) step();
    a_raw = 1'b0; repeat (10) step();
    b_raw = 1'b1; repeat (10) step();
    b_raw = 1'b0; repeat (10) step();
    check("abro_a_rise", a_rise_n, 1);
    check("abro_a_fall", a_fall_n, 1);
    check("abro_a_toggles", a_tog_n, 2);
    check("abro_b_rise", b_rise_n, 1);
    check("abro_b_fall", b_fall_n, 1);
    check("abro_b_toggles", b_tog_n, 2);
    check("abro_final_clean", 32'({a_clean, b_clean}), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
